// File: rtl/change_dispenser.sv
// Coin-return dispenser: plans a greedy 10/5 breakdown of a change amount
// against its own coin inventory and pays it out one coin per valid/ack handshake.
module change_dispenser #(
  parameter int AMT_W  = 8,
  parameter int CNT_W  = 6,
  parameter int INIT10 = 8,
  parameter int INIT5  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             coin_ack,
  output logic [3:0]       coin,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5
);

  typedef enum logic [2:0] {IDLE, CHECK, DISP, DONE, ERR} state_t;

  localparam int PW = AMT_W + CNT_W;

  state_t           state, state_next;
  logic [AMT_W-1:0] amt_r, amt_next;
  logic [CNT_W-1:0] left10, left10_next;
  logic [CNT_W-1:0] left5, left5_next;
  logic [CNT_W-1:0] cnt10_r, cnt10_next;
  logic [CNT_W-1:0] cnt5_r, cnt5_next;
  logic [3:0]       coin_r, coin_next;
  logic             coin_valid_r, coin_valid_next;

  // Breakdown plan, evaluated at full product width so 10*n10 never truncates
  logic [PW-1:0] amt_w, q10, n10, prod, rem, n5;
  logic          not_mult5, short5, last_coin;

  always_comb begin
    amt_w     = PW'(amt_r);
    q10       = amt_w / PW'(10);
    n10       = (q10 < PW'(cnt10_r)) ? q10 : PW'(cnt10_r);
    prod      = n10 * PW'(10);
    rem       = amt_w - prod;
    n5        = rem / PW'(5);
    not_mult5 = (amt_w % PW'(5)) != '0;
    short5    = n5 > PW'(cnt5_r);
    last_coin = ((left10 == CNT_W'(1)) && (left5 == '0)) ||
                ((left10 == '0) && (left5 == CNT_W'(1)));
  end

  always_comb begin
    state_next  = state;
    amt_next    = amt_r;
    left10_next = left10;
    left5_next  = left5;
    cnt10_next  = cnt10_r;
    cnt5_next   = cnt5_r;

    case (state)
      IDLE: begin
        if (refill) begin
          cnt10_next = CNT_W'(INIT10);
          cnt5_next  = CNT_W'(INIT5);
        end else if (req) begin
          amt_next   = amount;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (not_mult5 || short5) begin
          state_next = ERR;
        end else if ((n10 == '0) && (n5 == '0)) begin
          state_next = DONE;
        end else begin
          left10_next = CNT_W'(n10);
          left5_next  = CNT_W'(n5);
          state_next  = DISP;
        end
      end
      DISP: begin
        if (coin_valid_r && coin_ack) begin
          if (left10 != '0) begin
            left10_next = left10 - CNT_W'(1);
            cnt10_next  = cnt10_r - CNT_W'(1);
          end else begin
            left5_next = left5 - CNT_W'(1);
            cnt5_next  = cnt5_r - CNT_W'(1);
          end
          if (last_coin) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Coin outputs are registered from the next-state view so they line up with DISP
    coin_valid_next = (state_next == DISP);
    coin_next       = 4'd0;
    if (coin_valid_next) coin_next = (left10_next != '0) ? 4'd10 : 4'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      amt_r        <= '0;
      left10       <= '0;
      left5        <= '0;
      cnt10_r      <= CNT_W'(INIT10);
      cnt5_r       <= CNT_W'(INIT5);
      coin_r       <= '0;
      coin_valid_r <= 1'b0;
    end else begin
      state        <= state_next;
      amt_r        <= amt_next;
      left10       <= left10_next;
      left5        <= left5_next;
      cnt10_r      <= cnt10_next;
      cnt5_r       <= cnt5_next;
      coin_r       <= coin_next;
      coin_valid_r <= coin_valid_next;
    end
  end

  assign coin       = coin_r;
  assign coin_valid = coin_valid_r;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign cnt10      = cnt10_r;
  assign cnt5       = cnt5_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: expected coins are queued from a greedy model
// when a request is driven and popped as the hopper acks each coin.
module tb_change_dispenser;

  localparam int AMT_W  = 8;
  localparam int CNT_W  = 6;
  localparam int INIT10 = 8;
  localparam int INIT5  = 8;

  logic             clk = 1'b0;
  logic             rst, req, refill, coin_ack;
  logic [AMT_W-1:0] amount;
  logic [3:0]       coin;
  logic             coin_valid, busy, done, err;
  logic [CNT_W-1:0] cnt10, cnt5;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int inv10, inv5;

  always #5 clk = ~clk;

  change_dispenser #(
    .AMT_W (AMT_W),
    .CNT_W (CNT_W),
    .INIT10(INIT10),
    .INIT5 (INIT5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .amount    (amount),
    .refill    (refill),
    .coin_ack  (coin_ack),
    .coin      (coin),
    .coin_valid(coin_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cnt10     (cnt10),
    .cnt5      (cnt5)
  );

  task automatic plan_push(input int amt);
    int q, n10, rem, n5;
    q   = amt / 10;
    n10 = (q < inv10) ? q : inv10;
    rem = amt - 10 * n10;
    n5  = rem / 5;
    if (!((amt % 5) != 0 || n5 > inv5)) begin
      repeat (n10) exp_q.push_back(10);
      repeat (n5)  exp_q.push_back(5);
      inv10 -= n10;
      inv5  -= n5;
    end
  endtask

  task automatic request(input int amt);
    @(posedge clk); #1;
    req    = 1'b1;
    amount = AMT_W'(amt);
    plan_push(amt);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Runs one transaction from T+1 (c=1) until done/err; scoreboard compares on each ack
  task automatic collect(input int stall, input int poke, input int maxc,
                         output int ncoins, output int c_first, output int c_done,
                         output int c_err, output int n10cyc);
    int stall_left, expv;
    logic [3:0] held;
    logic holding;
    ncoins = 0; c_first = -1; c_done = -1; c_err = -1; n10cyc = 0;
    stall_left = stall; holding = 1'b0; held = 4'd0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (busy !== 1'b1 || coin_valid !== 1'b0) begin
          bad++;
          $display("FAIL check_cycle: got busy=%0b coin_valid=%0b, required busy=1 coin_valid=0", busy, coin_valid);
        end
      end
      if (coin_valid === 1'b1) begin
        if (c_first < 0) c_first = c;
        if (holding) begin
          total++;
          if (coin !== held) begin
            bad++;
            $display("FAIL coin_stable: got coin=%0d, required %0d", coin, held);
          end
        end
        if (coin == 4'd10) n10cyc++;
        if (stall_left > 0) begin
          coin_ack = 1'b0;
          stall_left--;
        end else begin
          coin_ack = 1'b1;
        end
        if (coin_ack) begin
          ncoins++;
          total++;
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_extra: got coin=%0d, required no coin", coin);
          end else begin
            expv = exp_q.pop_front();
            if (coin !== 4'(expv)) begin
              bad++;
              $display("FAIL scoreboard_coin: got coin=%0d, required %0d", coin, expv);
            end
          end
        end else begin
          holding = 1'b1;
          held    = coin;
        end
      end else begin
        coin_ack = 1'b1;
        total++;
        if (coin !== 4'd0) begin
          bad++;
          $display("FAIL coin_idle: got coin=%0d, required 0", coin);
        end
      end
      if (poke != 0) begin
        req    = (c == c_first);
        refill = (c == c_first);
        amount = AMT_W'(50);
      end
      if (done === 1'b1 && c_done < 0) c_done = c;
      if (err === 1'b1 && c_err < 0) c_err = c;
      if (c_done >= 0 || c_err >= 0) break;
    end
    if (c_done < 0 && c_err < 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done/err in %0d cycles, required one", maxc);
    end
    coin_ack = 1'b1;
    req      = 1'b0;
    refill   = 1'b0;
  endtask

  task automatic do_refill();
    @(posedge clk); #1;
    refill = 1'b1;
    req    = 1'b1;
    amount = AMT_W'(5);
    @(posedge clk); #1;
    refill = 1'b0;
    req    = 1'b0;
    inv10  = INIT10;
    inv5   = INIT5;
    @(negedge clk);
    total++;
    if (cnt10 !== CNT_W'(INIT10) || cnt5 !== CNT_W'(INIT5) || busy !== 1'b0) begin
      bad++;
      $display("FAIL refill: got cnt10=%0d cnt5=%0d busy=%0b, required %0d %0d 0", cnt10, cnt5, busy, INIT10, INIT5);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; refill = 1'b0; coin_ack = 1'b1; amount = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (coin !== 4'd0 || coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got coin=%0d valid=%0b busy=%0b done=%0b err=%0b, required all 0", coin, coin_valid, busy, done, err);
    end
    total++;
    if (cnt10 !== 6'd8 || cnt5 !== 6'd8) begin
      bad++;
      $display("FAIL reset_inventory: got cnt10=%0d cnt5=%0d, required 8 8", cnt10, cnt5);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    inv10 = INIT10;
    inv5  = INIT5;
  endtask

  task automatic test_greedy();
    int n, cf, cd, ce, n10c;
    request(25);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    total++;
    if (cf !== 2 || n !== 3 || cd !== 5) begin
      bad++;
      $display("FAIL greedy_timing: got first=%0d coins=%0d done=%0d, required 2 3 5", cf, n, cd);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cnt10 !== 6'd6 || cnt5 !== 6'd7 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL greedy_end: got busy=%0b cnt10=%0d cnt5=%0d left=%0d, required 0 6 7 0", busy, cnt10, cnt5, exp_q.size());
    end
  endtask

  task automatic test_bad_amount();
    int n, cf, cd, ce, n10c;
    do_refill();
    request(7);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    total++;
    if (ce !== 2 || n !== 0 || cf !== -1) begin
      bad++;
      $display("FAIL bad_amount: got err_cycle=%0d coins=%0d first=%0d, required 2 0 -1", ce, n, cf);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cnt10 !== 6'd8 || cnt5 !== 6'd8) begin
      bad++;
      $display("FAIL bad_amount_end: got busy=%0b cnt10=%0d cnt5=%0d, required 0 8 8", busy, cnt10, cnt5);
    end
  endtask

  task automatic test_drain();
    int n, cf, cd, ce, n10c;
    request(100);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    @(negedge clk);
    total++;
    if (n !== 12 || n10c !== 8 || cnt10 !== 6'd0 || cnt5 !== 6'd4) begin
      bad++;
      $display("FAIL drain: got coins=%0d tens=%0d cnt10=%0d cnt5=%0d, required 12 8 0 4", n, n10c, cnt10, cnt5);
    end
    request(30);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    total++;
    if (ce !== 2 || n !== 0) begin
      bad++;
      $display("FAIL shortfall: got err_cycle=%0d coins=%0d, required 2 0", ce, n);
    end
    do_refill();
  endtask

  task automatic test_stall();
    int n, cf, cd, ce, n10c;
    request(15);
    collect(3, 0, 40, n, cf, cd, ce, n10c);
    total++;
    if (n10c !== 4 || n !== 2 || cd !== 7) begin
      bad++;
      $display("FAIL stall: got ten_cycles=%0d coins=%0d done=%0d, required 4 2 7", n10c, n, cd);
    end
    @(negedge clk);
    total++;
    if (cnt10 !== 6'd7 || cnt5 !== 6'd7) begin
      bad++;
      $display("FAIL stall_inventory: got cnt10=%0d cnt5=%0d, required 7 7", cnt10, cnt5);
    end
  endtask

  task automatic test_zero_and_ignore();
    int n, cf, cd, ce, n10c;
    request(0);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    total++;
    if (cd !== 2 || n !== 0 || cf !== -1) begin
      bad++;
      $display("FAIL zero_amount: got done=%0d coins=%0d first=%0d, required 2 0 -1", cd, n, cf);
    end
    request(20);
    collect(0, 1, 40, n, cf, cd, ce, n10c);
    total++;
    if (n !== 2 || n10c !== 2 || cd !== 4) begin
      bad++;
      $display("FAIL ignore_in_disp: got coins=%0d tens=%0d done=%0d, required 2 2 4", n, n10c, cd);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cnt10 !== 6'd5 || cnt5 !== 6'd7) begin
      bad++;
      $display("FAIL ignore_end: got busy=%0b cnt10=%0d cnt5=%0d, required 0 5 7", busy, cnt10, cnt5);
    end
  endtask

  task automatic test_reset_mid();
    int n, cf, cd, ce, n10c, expv;
    request(20);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (coin_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL reset_mid_first: got coin_valid=%0b queued=%0d, required 1 and queued>0", coin_valid, exp_q.size());
    end else begin
      expv = exp_q.pop_front();
      if (coin !== 4'(expv)) begin
        bad++;
        $display("FAIL reset_mid_first: got coin=%0d, required %0d", coin, expv);
      end
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    coin_ack = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    coin_ack = 1'b1;
    exp_q.delete();
    inv10 = INIT10;
    inv5  = INIT5;
    @(negedge clk);
    total++;
    if (coin !== 4'd0 || coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        cnt10 !== 6'd8 || cnt5 !== 6'd8) begin
      bad++;
      $display("FAIL reset_mid: got coin=%0d valid=%0b busy=%0b done=%0b err=%0b cnt10=%0d cnt5=%0d, required 0 0 0 0 0 8 8",
               coin, coin_valid, busy, done, err, cnt10, cnt5);
    end
    request(10);
    collect(0, 0, 40, n, cf, cd, ce, n10c);
    @(negedge clk);
    total++;
    if (n !== 1 || cd !== 3 || cnt10 !== 6'd7 || cnt5 !== 6'd8) begin
      bad++;
      $display("FAIL after_reset: got coins=%0d done=%0d cnt10=%0d cnt5=%0d, required 1 3 7 8", n, cd, cnt10, cnt5);
    end
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_bad_amount();
    test_drain();
    test_stall();
    test_zero_and_ignore();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d queued, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
